probe_sequencer: RTL and testbench
==================================

# probe_sequencer

Page controller for the on-board 7-segment probe. Turns two raw pushbuttons into the 4-bit page `select` that drives the probe display mux. Handles input synchronisation, debounce and page wrap. Optionally auto-scans through the pages on a fixed dwell so the ant-farm state can be watched hands-free.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a key change is accepted (20 ms at 50 MHz); must be ≥ 2.
- `DWELL_CYCLES`, default 100000000: cycles per page in auto-scan; must be ≥ 2.
- `NUM_PAGES`, default 4: number of valid pages, 1..16; `select` ranges 0..NUM_PAGES-1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_next_n`  in  1  raw pushbutton, active-low, asynchronous to `clk`; advances the page.
- `key_prev_n`  in  1  raw pushbutton, active-low, asynchronous; steps back one page.
- `hold`  in  1  synchronous freeze; while 1, key presses are discarded and the dwell counter stalls.
- `auto_en`  in  1  synchronous slide switch, 1 = request auto-scan.
- `select`  out  4  current page index, registered.
- `page_changed`  out  1  one-cycle pulse in the cycle `select` takes a new value.
- `auto_active`  out  1  1 while in state AUTO.

## Operation
- Each key passes through a 2-flop synchroniser, then its own debouncer.
- Debouncer:
  - It holds a debounced level (reset 1 = released) and a counter.
  - The counter clears whenever the synchronised level equals the debounced level, and increments otherwise.
  - When the counter is at DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
- A press is a debounced 1→0 transition. Releases have no effect.
- Next press: `select` ← (select == NUM_PAGES-1) ? 0 : select+1.
- Prev press: `select` ← (select == 0) ? NUM_PAGES-1 : select-1.
- Next and prev presses detected in the same cycle cancel: `select` is unchanged and no pulse is issued.
- Presses detected while `hold`=1 are dropped, not queued. The debouncers keep running during `hold`.
- NUM_PAGES = 1: `select` stays 0 and `page_changed` never asserts.
- State machine (2 states):
  - MANUAL (reset): pages change only on presses; the dwell counter is held at 0. MANUAL→AUTO when `auto_en`=1.
  - AUTO: the dwell counter increments each cycle with `hold`=0. At DWELL_CYCLES-1 it performs a next-step and clears.
  - In AUTO, any accepted press applies its step and clears the dwell counter.
  - A dwell expiry coinciding with a press: the press wins, only one step is taken, and the counter clears.
  - AUTO→MANUAL when `auto_en`=0; the dwell counter clears and `select` is retained.
- `page_changed` asserts only when the new `select` differs from the old one.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - `select`=0, `page_changed`=0, `auto_active`=0.
  - State MANUAL, synchronisers=1, debounced levels=1, all counters 0.
- Key latency: a raw falling edge held stable updates `select` 2 + DEBOUNCE_CYCLES + 1 rising edges later. `page_changed` is high in that same cycle only.
- Glitch rejection: bounce shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no press.
- Auto-scan period: exactly DWELL_CYCLES cycles between successive `page_changed` pulses with `hold`=0. Stalled `hold` cycles extend the period one-for-one.
- `auto_active` changes one cycle after `auto_en` is sampled.
- Reset mid-debounce or mid-dwell: all progress is lost and the block returns to reset values immediately.

## Configuration
- `PROBE_AUTOSCAN_EN` defined: the AUTO state, dwell counter and `auto_en` logic are built as described.
- Undefined:
  - `auto_en` is ignored, the state is permanently MANUAL and `auto_active` is tied 0. No dwell counter is synthesised.
  - Manual behaviour is identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, DWELL_CYCLES=10, NUM_PAGES=4.
- Reset, then a clean `key_next_n` low held 20 cycles → `select` 0→1 exactly 7 cycles after the edge, one-cycle `page_changed`, no further change on release.
- Four clean next presses from 0 → sequence 1,2,3,0. Then one prev press → 3.
- `key_next_n` toggling every 2 cycles for 30 cycles, then released → `select` unchanged and no pulse.
- Next and prev asserted on the same edge, stable 10 cycles → `select` unchanged and no pulse. A next press with `hold`=1 → dropped.
- With the macro: `auto_en`=1 → `select` steps 0,1,2,3,0 every 10 cycles. A next press at dwell count 5 steps once and restarts the 10-cycle dwell. `auto_en`=0 → stepping stops and `select` is held.
- Without the macro: `auto_en`=1 for 50 cycles → `select` stays 0 and `auto_active`=0. Assert `rst_n` low mid-dwell (macro build) → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/probe_sequencer.sv
// Page controller for the 7-segment probe: synchronises and debounces two pushbuttons
// into a wrapping page index. Auto-scan is built only when PROBE_AUTOSCAN_EN is defined.
module probe_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DWELL_CYCLES    = 100000000,
  parameter int unsigned NUM_PAGES       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_next_n,
  input  logic       key_prev_n,
  input  logic       hold,
  input  logic       auto_en,
  output logic [3:0] select,
  output logic       page_changed,
  output logic       auto_active
);

  localparam int unsigned SEL_W = 4;
  localparam int unsigned KEY_N = 2;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned DW_W  = $clog2(DWELL_CYCLES);

  localparam logic [SEL_W-1:0] LAST_PAGE = SEL_W'(NUM_PAGES - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0]  DW_LAST   = DW_W'(DWELL_CYCLES - 1);

  // Key index 0 is "next", index 1 is "prev"; all key levels are active-low.
  logic [KEY_N-1:0]           key_raw_c;
  logic [KEY_N-1:0]           sync1_q, sync2_q;
  logic [KEY_N-1:0]           deb_q, deb_d, deb_prev_q;
  logic [KEY_N-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [KEY_N-1:0]           press_c;
  logic                       accept_c;
  logic                       dwell_step_c;

  logic [SEL_W-1:0]           select_q, select_d;
  logic                       page_changed_q;

  function automatic logic [SEL_W-1:0] page_inc(input logic [SEL_W-1:0] p);
    return (p == LAST_PAGE) ? '0 : p + SEL_W'(1);
  endfunction

  function automatic logic [SEL_W-1:0] page_dec(input logic [SEL_W-1:0] p);
    return (p == '0) ? LAST_PAGE : p - SEL_W'(1);
  endfunction

  assign key_raw_c = {key_prev_n, key_next_n};

  // Two-flop synchroniser per key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_raw_c;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int k = 0; k < KEY_N; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          deb_d[k] = ~deb_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q      <= '1;
      deb_prev_q <= '1;
      db_cnt_q   <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // A press is a registered debounced 1->0 edge; hold discards it outright.
  assign press_c  = deb_prev_q & ~deb_q;
  assign accept_c = (|press_c) & ~hold;

`ifdef PROBE_AUTOSCAN_EN
  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            auto_active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_MANUAL;
      dwell_q       <= '0;
      auto_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      auto_active_q <= (state_d == ST_AUTO);
    end
  end

  // Presses restart the dwell and take priority over a coincident expiry.
  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    dwell_step_c = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        dwell_d = '0;
        if (auto_en) begin
          state_d = ST_AUTO;
        end
      end
      ST_AUTO: begin
        if (!auto_en) begin
          state_d = ST_MANUAL;
          dwell_d = '0;
        end else if (accept_c) begin
          dwell_d = '0;
        end else if (!hold) begin
          if (dwell_q == DW_LAST) begin
            dwell_d      = '0;
            dwell_step_c = 1'b1;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_MANUAL;
        dwell_d = '0;
      end
    endcase
  end

  assign auto_active = auto_active_q;
`else
  logic            unused_auto_en;
  logic [DW_W-1:0] unused_dwell_last;

  assign unused_auto_en    = auto_en;
  assign unused_dwell_last = DW_LAST;
  assign dwell_step_c      = 1'b0;
  assign auto_active       = 1'b0;
`endif

  // Simultaneous next and prev cancel each other.
  always_comb begin
    select_d = select_q;
    if (accept_c) begin
      case (press_c)
        2'b01:   select_d = page_inc(select_q);
        2'b10:   select_d = page_dec(select_q);
        default: select_d = select_q;
      endcase
    end else if (dwell_step_c) begin
      select_d = page_inc(select_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      select_q       <= '0;
      page_changed_q <= 1'b0;
    end else begin
      select_q       <= select_d;
      page_changed_q <= (select_d != select_q);
    end
  end

  assign select       = select_q;
  assign page_changed = page_changed_q;

endmodule

// File: tb/tb_probe_sequencer.sv
// Self-checking bench for probe_sequencer: directed scenarios plus random key/hold/auto traffic,
// checked every cycle against a behavioural model. Honours PROBE_AUTOSCAN_EN like the DUT.
module tb_probe_sequencer;

  localparam int DEB   = 4;
  localparam int DWELL = 10;
  localparam int NP    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_next_n = 1'b1;
  logic       key_prev_n = 1'b1;
  logic       hold = 1'b0;
  logic       auto_en = 1'b0;
  logic [3:0] select;
  logic       page_changed;
  logic       auto_active;

  int n_cmp = 0;
  int n_err = 0;

  probe_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .DWELL_CYCLES   (DWELL),
    .NUM_PAGES      (NP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_next_n  (key_next_n),
    .key_prev_n  (key_prev_n),
    .hold        (hold),
    .auto_en     (auto_en),
    .select      (select),
    .page_changed(page_changed),
    .auto_active (auto_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       sel;
    logic             chg;
    logic             aut;
    logic [31:0]      dwell;   // cycles elapsed in the current dwell
    logic [1:0]       deb;     // debounced levels
    logic [1:0]       pend;    // press seen, takes effect on the next edge
    logic [1:0][31:0] run;     // consecutive samples disagreeing with debounced level
    logic [1:0]       d1, d2;  // raw samples from one and two edges ago
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t r;
    r       = '0;
    r.deb   = 2'b11;
    r.d1    = 2'b11;
    r.d2    = 2'b11;
    return r;
  endfunction

  function automatic logic [3:0] wrap(input int v);
    return 4'(((v % NP) + NP) % NP);
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic [1:0] raw,
                                         input logic h, input logic ae);
    mstate_t n;
    logic    acc;
    logic    astep;
    int      net;
    logic [3:0] nsel;
    n     = s;
    acc   = (|s.pend) && !h;
    astep = 1'b0;
    nsel  = s.sel;
`ifdef PROBE_AUTOSCAN_EN
    if (s.aut) begin
      if (!ae) begin
        n.aut   = 1'b0;
        n.dwell = 0;
      end else if (acc) begin
        n.dwell = 0;
      end else if (!h) begin
        n.dwell = s.dwell + 1;
        if (n.dwell == 32'(DWELL)) begin
          n.dwell = 0;
          astep   = 1'b1;
        end
      end
    end else if (ae) begin
      n.aut = 1'b1;
    end
`else
    if (ae) n.dwell = 0;
`endif
    if (acc) begin
      net  = int'(s.pend[0]) - int'(s.pend[1]);
      nsel = wrap(int'(s.sel) + net);
    end else if (astep) begin
      nsel = wrap(int'(s.sel) + 1);
    end
    n.chg  = (nsel != s.sel);
    n.sel  = nsel;
    n.pend = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (s.d2[k] != s.deb[k]) begin
        n.run[k] = s.run[k] + 1;
        if (n.run[k] == 32'(DEB)) begin
          n.run[k]  = 0;
          n.deb[k]  = ~s.deb[k];
          n.pend[k] = s.deb[k];
        end
      end else begin
        n.run[k] = 0;
      end
    end
    n.d2 = s.d1;
    n.d1 = raw;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, {key_prev_n, key_next_n}, hold, auto_en);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle, then compare all outputs with the model.
  task automatic tick();
    @(negedge clk);
    chk("select", 32'(select), 32'(m.sel));
    chk("page_changed", 32'(page_changed), 32'(m.chg));
    chk("auto_active", 32'(auto_active), 32'(m.aut));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit prev, input int len);
    if (prev) key_prev_n = 1'b0; else key_next_n = 1'b0;
    ticks(len);
    key_prev_n = 1'b1;
    key_next_n = 1'b1;
    ticks(len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ticks(3);
    chk("reset_select", 32'(select), 0);
    chk("reset_pulse", 32'(page_changed), 0);
    chk("reset_auto", 32'(auto_active), 0);
    rst_n = 1'b1;
    ticks(2);

    // First press: select changes exactly 7 edges after the raw edge.
    key_next_n = 1'b0;
    ticks(6);
    chk("latency_before", 32'(select), 0);
    tick();
    chk("latency_select", 32'(select), 1);
    chk("latency_pulse", 32'(page_changed), 1);
    tick();
    chk("pulse_width", 32'(page_changed), 0);
    ticks(12);
    key_next_n = 1'b1;
    ticks(20);
    chk("release_no_effect", 32'(select), 1);

    press(1'b0, 10);
    chk("next_2", 32'(select), 2);
    press(1'b0, 10);
    chk("next_3", 32'(select), 3);
    press(1'b0, 10);
    chk("next_wrap_0", 32'(select), 0);
    press(1'b1, 10);
    chk("prev_wrap_3", 32'(select), 3);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 15; i++) begin
      key_next_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      ticks(2);
    end
    key_next_n = 1'b1;
    ticks(10);
    chk("bounce_rejected", 32'(select), 3);

    key_next_n = 1'b0;
    key_prev_n = 1'b0;
    ticks(10);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    ticks(10);
    chk("cancel_both", 32'(select), 3);

    hold = 1'b1;
    press(1'b0, 10);
    hold = 1'b0;
    ticks(2);
    chk("hold_drop", 32'(select), 3);

`ifdef PROBE_AUTOSCAN_EN
    auto_en = 1'b1;
    tick();
    chk("auto_enter", 32'(auto_active), 1);
    ticks(9);
    chk("dwell_before", 32'(select), 3);
    tick();
    chk("dwell_step_0", 32'(select), 0);
    chk("dwell_pulse", 32'(page_changed), 1);
    ticks(10);
    chk("dwell_step_1", 32'(select), 1);
    // Raw press timed so it lands around dwell count 5; model tracks the restart.
    key_next_n = 1'b0;
    ticks(10);
    key_next_n = 1'b1;
    ticks(25);
    auto_en = 1'b0;
    tick();
    chk("auto_exit", 32'(auto_active), 0);
    ticks(30);
`else
    auto_en = 1'b1;
    ticks(50);
    chk("noauto_select", 32'(select), 3);
    chk("noauto_active", 32'(auto_active), 0);
    auto_en = 1'b0;
    tick();
`endif

    // Random traffic.
    for (int seg = 0; seg < 400; seg++) begin
      key_next_n = ($urandom_range(0, 2) != 0);
      key_prev_n = ($urandom_range(0, 3) != 0);
      hold       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) auto_en = ~auto_en;
      ticks(int'($urandom_range(1, 12)));
    end
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    hold       = 1'b0;

    // Asynchronous reset in the middle of a dwell.
    auto_en = 1'b1;
    ticks(15);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_select", 32'(select), 0);
    chk("async_rst_pulse", 32'(page_changed), 0);
    chk("async_rst_auto", 32'(auto_active), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
